sort_sequence_datapath: RTL and testbench
=========================================

// Module: sort_sequence_datapath
// PURPOSE
//   Responder side of the sort-sequence go/done handshake.
//   Each go_* strobe from the sort controller starts one datapath operation, which answers on its matching done line.
//   The block topologically orders up to N_NODES nodes: valid nodes listed in index order, then placed one at a time.
//   A node is placed only once all of its valid dependencies are placed. The result is the node_seq output.
// PARAMETERS
//   N_NODES  8  max nodes (power of 2, >=2)
//   IDX_W    3  node index width, = log2(N_NODES)
// PORTS
//   clk                  in   1              system clock, all state on posedge
//   program_reset        in   1              synchronous active-high reset
//   node_valid_mask      in   N_NODES        bit i = node i participates; held stable while sorting
//   dep_mask             in   N_NODES*N_NODES  row i at [i*N_NODES +: N_NODES]; bit j = node i needs node j first
//   go_reset_data        in   1              clear working state
//   go_calculate_width   in   1              count valid nodes
//   go_set_element_seq   in   1              build compacted element list
//   go_choose_next_node  in   1              find next unplaced candidate
//   go_check_node        in   1              test candidate dependencies
//   go_set_node_seq      in   1              place candidate
//   data_reset_done      out  1              level
//   width_calculated     out  1              1-cycle pulse
//   element_seq_set      out  1              1-cycle pulse
//   node_chosen          out  1              1-cycle pulse
//   all_nodes_set        out  1              level
//   node_checked         out  1              1-cycle pulse
//   node_valid           out  1              qualified by node_checked
//   node_seq_set         out  1              1-cycle pulse
//   node_seq             out  N_NODES*IDX_W  slot k at [k*IDX_W +: IDX_W] = k-th placed node
//   seq_count            out  IDX_W+1        nodes placed so far
//   cycle_error          out  1              sticky: dependency cycle or missing dependency found
// BEHAVIOUR
//   Reset: all outputs, placed mask, width, cursor, fail count, element list, node_seq and seq_count = 0.
//   Start: each operation starts on the rising edge of its go (go=1, previous-cycle go=0).
//   After completion the unit idles until its go falls.
//   Overlapping gos are not expected. If more than one go is high, the lowest-listed go wins.
//   Reset data: the cycle after start, placed/seq_count/node_seq/cursor/fail/cycle_error are cleared.
//     Then data_reset_done=1 and is held while go_reset_data=1. It is 0 the cycle after go_reset_data falls.
//   Width: scan node_valid_mask one bit per cycle; width = popcount.
//     width_calculated pulses on the cycle after the last bit is counted, i.e. N_NODES+1 cycles after start.
//   Element list: write valid indices, ascending, into list[0..width-1], one per cycle.
//     element_seq_set pulses N_NODES+1 cycles after start.
//   Choose: scan list from cursor, one entry per cycle; the cursor wraps at width.
//     The first entry not yet placed becomes cand. node_chosen pulses on the cycle after that entry is examined.
//     Then cursor = cand_pos+1 (wrapped).
//     If width==0, seq_count==width or cycle_error=1, all_nodes_set=1 from the cycle after start.
//     all_nodes_set is held while go_choose_next_node=1; node_chosen is not pulsed.
//   Check: single cycle. node_checked pulses the cycle after start.
//     node_valid = ((row[cand] & node_valid_mask & ~placed) == 0) && ((row[cand] & ~node_valid_mask) == 0).
//     If valid, fail <= 0. Else fail <= fail+1.
//     If fail+1 == width - seq_count, cycle_error <= 1.
//   Set: the cycle after start, node_seq[seq_count] <= cand, placed[cand] <= 1, seq_count++, fail <= 0.
//     node_seq_set pulses that same cycle.
//   program_reset mid-operation: abort immediately; all state returns to reset values.
//   A go that is still high after reset does not restart until it falls and rises again.
//   Pulsed done outputs are 0 whenever the matching go is 0.
// TESTING
//   Reset: pulse program_reset during a width scan.
//     -> all outputs 0 next cycle; no width_calculated pulse.
//   Chain: N=8, valid=8'h0F, deps 1->0, 2->1, 3->2, nodes in reverse index order.
//     -> node_seq slots 0..3 = 0,1,2,3; seq_count=4; all_nodes_set; cycle_error=0.
//   Independent: valid=8'hFF, dep_mask=0.
//     -> width=8; node_seq = 0..7 in order; zero failed checks.
//   Cycle: valid=8'h07, node 0 needs 1, node 1 needs 0, node 2 free.
//     -> node 2 is placed; cycle_error=1 after two consecutive fails; all_nodes_set on the next choose; seq_count=1.
//   Empty: valid=8'h00.
//     -> width_calculated after 9 cycles; all_nodes_set on the first choose; seq_count=0.
//   Handshake: hold go_reset_data high for 5 cycles.
//     -> data_reset_done high from cycle 2 to 5; low one cycle after go falls.

Source files
------------

// File: rtl/sort_sequence_datapath.sv
// Responder for the sort controller's go/done handshake: each go rising edge runs one datapath step of a topological node sort.
// Latency: 1 cycle (reset/check/set), N_NODES+1 (width/element list), 1+entries scanned (choose); no backpressure, done held until go falls.
module sort_sequence_datapath #(
  parameter int N_NODES = 8,
  parameter int IDX_W   = 3
) (
  input  logic                       clk,
  input  logic                       program_reset,
  input  logic [N_NODES-1:0]         node_valid_mask,
  input  logic [N_NODES*N_NODES-1:0] dep_mask,
  input  logic                       go_reset_data,
  input  logic                       go_calculate_width,
  input  logic                       go_set_element_seq,
  input  logic                       go_choose_next_node,
  input  logic                       go_check_node,
  input  logic                       go_set_node_seq,
  output logic                       data_reset_done,
  output logic                       width_calculated,
  output logic                       element_seq_set,
  output logic                       node_chosen,
  output logic                       all_nodes_set,
  output logic                       node_checked,
  output logic                       node_valid,
  output logic                       node_seq_set,
  output logic [N_NODES*IDX_W-1:0]   node_seq,
  output logic [IDX_W:0]             seq_count,
  output logic                       cycle_error
);

  localparam int N_OPS = 6;
  localparam logic [2:0] OP_RST    = 3'd0;
  localparam logic [2:0] OP_WID    = 3'd1;
  localparam logic [2:0] OP_ELEM   = 3'd2;
  localparam logic [2:0] OP_CHOOSE = 3'd3;
  localparam logic [2:0] OP_CHECK  = 3'd4;
  localparam logic [2:0] OP_SET    = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_R_HOLD, S_W_SCAN, S_W_DONE, S_E_SCAN, S_E_DONE,
    S_C_SCAN, S_C_DONE, S_C_ALL, S_K_DONE, S_S_DONE, S_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [2:0] op_q, op_d;

  logic [N_OPS-1:0] go_vec, go_prev_q, go_rise, start;

  logic [IDX_W:0]   width_q, fail_q, seq_count_q, steps_q, wptr_q;
  logic [IDX_W-1:0] cursor_q, pos_q, cand_q, scan_idx_q;
  logic [N_NODES-1:0] placed_q;
  logic [IDX_W-1:0] list_q [N_NODES];
  logic [IDX_W-1:0] seq_q  [N_NODES];
  logic cycle_error_q, node_valid_q;

  logic [IDX_W-1:0]   entry, pos_next;
  logic               entry_placed, all_done, cand_ok;
  logic [N_NODES-1:0] cand_row;
  logic [IDX_W:0]     fail_inc, remaining;

  assign go_vec  = {go_set_node_seq, go_check_node, go_choose_next_node,
                    go_set_element_seq, go_calculate_width, go_reset_data};
  assign go_rise = go_vec & ~go_prev_q;
  // Isolate the lowest set bit so the first-listed go wins on overlap.
  assign start   = (state_q == S_IDLE) ? (go_rise & (~go_rise + N_OPS'(1))) : '0;

  assign entry        = list_q[pos_q];
  assign entry_placed = placed_q[entry];
  assign pos_next     = (({1'b0, pos_q} + (IDX_W+1)'(1)) == width_q) ? '0 : pos_q + IDX_W'(1);
  assign all_done     = (width_q == '0) || (seq_count_q == width_q) || cycle_error_q;
  assign cand_row     = dep_mask[cand_q*N_NODES +: N_NODES];
  assign cand_ok      = ((cand_row & node_valid_mask & ~placed_q) == '0) &&
                        ((cand_row & ~node_valid_mask) == '0);
  assign fail_inc     = fail_q + (IDX_W+1)'(1);
  assign remaining    = width_q - seq_count_q;

  always_ff @(posedge clk) begin
    if (program_reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_RST;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Tracks go levels even through reset so a go still high afterwards cannot retrigger.
  always_ff @(posedge clk) begin
    go_prev_q <= go_vec;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (start[OP_RST]) begin
          state_d = S_R_HOLD;  op_d = OP_RST;
        end else if (start[OP_WID]) begin
          state_d = S_W_SCAN;  op_d = OP_WID;
        end else if (start[OP_ELEM]) begin
          state_d = S_E_SCAN;  op_d = OP_ELEM;
        end else if (start[OP_CHOOSE]) begin
          state_d = all_done ? S_C_ALL : S_C_SCAN;
          op_d    = OP_CHOOSE;
        end else if (start[OP_CHECK]) begin
          state_d = S_K_DONE;  op_d = OP_CHECK;
        end else if (start[OP_SET]) begin
          state_d = S_S_DONE;  op_d = OP_SET;
        end
      end
      S_R_HOLD, S_C_ALL, S_WAIT: begin
        if (!go_vec[op_q]) state_d = S_IDLE;
      end
      S_W_SCAN: begin
        if (scan_idx_q == IDX_W'(N_NODES-1)) state_d = S_W_DONE;
      end
      S_E_SCAN: begin
        if (scan_idx_q == IDX_W'(N_NODES-1)) state_d = S_E_DONE;
      end
      S_C_SCAN: begin
        if (!entry_placed) state_d = S_C_DONE;
        else if ((steps_q + (IDX_W+1)'(1)) >= width_q) state_d = S_C_ALL;
      end
      S_W_DONE, S_E_DONE, S_C_DONE, S_K_DONE, S_S_DONE: state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase

    data_reset_done  = (state_q == S_R_HOLD) && go_reset_data;
    width_calculated = (state_q == S_W_DONE) && go_calculate_width;
    element_seq_set  = (state_q == S_E_DONE) && go_set_element_seq;
    node_chosen      = (state_q == S_C_DONE) && go_choose_next_node;
    all_nodes_set    = (state_q == S_C_ALL)  && go_choose_next_node;
    node_checked     = (state_q == S_K_DONE) && go_check_node;
    node_valid       = node_checked && node_valid_q;
    node_seq_set     = (state_q == S_S_DONE) && go_set_node_seq;
    seq_count        = seq_count_q;
    cycle_error      = cycle_error_q;
    node_seq         = '0;
    for (int k = 0; k < N_NODES; k++) node_seq[k*IDX_W +: IDX_W] = seq_q[k];
  end

  always_ff @(posedge clk) begin
    if (program_reset) begin
      width_q       <= '0;
      fail_q        <= '0;
      seq_count_q   <= '0;
      steps_q       <= '0;
      wptr_q        <= '0;
      cursor_q      <= '0;
      pos_q         <= '0;
      cand_q        <= '0;
      scan_idx_q    <= '0;
      placed_q      <= '0;
      cycle_error_q <= 1'b0;
      node_valid_q  <= 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        list_q[i] <= '0;
        seq_q[i]  <= '0;
      end
    end else begin
      if (start[OP_RST]) begin
        placed_q      <= '0;
        seq_count_q   <= '0;
        cursor_q      <= '0;
        fail_q        <= '0;
        cycle_error_q <= 1'b0;
        for (int i = 0; i < N_NODES; i++) seq_q[i] <= '0;
      end
      if (start[OP_WID]) begin
        width_q    <= '0;
        scan_idx_q <= '0;
      end
      if (start[OP_ELEM]) begin
        wptr_q     <= '0;
        scan_idx_q <= '0;
      end
      if (start[OP_CHOOSE]) begin
        pos_q   <= cursor_q;
        steps_q <= '0;
      end
      if (start[OP_CHECK]) begin
        node_valid_q <= cand_ok;
        if (cand_ok) begin
          fail_q <= '0;
        end else begin
          fail_q <= fail_inc;
          // Every remaining candidate has failed in a row: nothing can ever be placed.
          if (fail_inc == remaining) cycle_error_q <= 1'b1;
        end
      end
      if (start[OP_SET]) begin
        if (seq_count_q < (IDX_W+1)'(N_NODES)) seq_q[seq_count_q[IDX_W-1:0]] <= cand_q;
        placed_q[cand_q] <= 1'b1;
        seq_count_q      <= seq_count_q + (IDX_W+1)'(1);
        fail_q           <= '0;
      end
      if (state_q == S_W_SCAN) begin
        width_q    <= width_q + (IDX_W+1)'(node_valid_mask[scan_idx_q]);
        scan_idx_q <= scan_idx_q + IDX_W'(1);
      end
      if (state_q == S_E_SCAN) begin
        if (node_valid_mask[scan_idx_q]) begin
          list_q[wptr_q[IDX_W-1:0]] <= scan_idx_q;
          wptr_q <= wptr_q + (IDX_W+1)'(1);
        end
        scan_idx_q <= scan_idx_q + IDX_W'(1);
      end
      if (state_q == S_C_SCAN) begin
        if (!entry_placed) begin
          cand_q   <= entry;
          cursor_q <= pos_next;
        end else begin
          pos_q   <= pos_next;
          steps_q <= steps_q + (IDX_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_sequence_datapath.sv
// Bench: drives the go/done handshake as the sort controller would and compares every answer against a behavioural topological-sort model.
module tb_sort_sequence_datapath;
  localparam int N = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic program_reset;
  logic [N-1:0] node_valid_mask;
  logic [N*N-1:0] dep_mask;
  logic [5:0] gov;
  logic data_reset_done, width_calculated, element_seq_set, node_chosen;
  logic all_nodes_set, node_checked, node_valid, node_seq_set, cycle_error;
  logic [N*W-1:0] node_seq;
  logic [W:0] seq_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic cap_valid, cap_all;

  always #5 clk = ~clk;

  sort_sequence_datapath #(.N_NODES(N), .IDX_W(W)) dut (
    .clk                (clk),
    .program_reset      (program_reset),
    .node_valid_mask    (node_valid_mask),
    .dep_mask           (dep_mask),
    .go_reset_data      (gov[0]),
    .go_calculate_width (gov[1]),
    .go_set_element_seq (gov[2]),
    .go_choose_next_node(gov[3]),
    .go_check_node      (gov[4]),
    .go_set_node_seq    (gov[5]),
    .data_reset_done    (data_reset_done),
    .width_calculated   (width_calculated),
    .element_seq_set    (element_seq_set),
    .node_chosen        (node_chosen),
    .all_nodes_set      (all_nodes_set),
    .node_checked       (node_checked),
    .node_valid         (node_valid),
    .node_seq_set       (node_seq_set),
    .node_seq           (node_seq),
    .seq_count          (seq_count),
    .cycle_error        (cycle_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic op_done(input int op);
    case (op)
      0:       return data_reset_done;
      1:       return width_calculated;
      2:       return element_seq_set;
      3:       return node_chosen | all_nodes_set;
      4:       return node_checked;
      default: return node_seq_set;
    endcase
  endfunction

  function automatic logic [63:0] out_vec();
    return {27'd0, data_reset_done, width_calculated, element_seq_set, node_chosen,
            all_nodes_set, node_checked, node_valid, node_seq_set, node_seq, seq_count, cycle_error};
  endfunction

  // Raise one go, wait (bounded) for its done, verify pulse/level shape and release.
  task automatic do_op(input int op, output int lat);
    logic hold_exp;
    gov[op] = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!op_done(op) && lat < 40);
    check_eq($sformatf("op%0d_done", op), op_done(op), 1'b1);
    cap_valid = node_valid;
    cap_all   = all_nodes_set;
    hold_exp  = (op == 0) || (op == 3 && cap_all);
    step();
    check_eq($sformatf("op%0d_shape", op), op_done(op), hold_exp);
    gov[op] = 1'b0;
    #1;
    check_eq($sformatf("op%0d_drop", op), op_done(op), 1'b0);
    step();
  endtask

  // Plays the controller's sort loop and checks each step against a list/queue model.
  task automatic run_sort(input string name, output int bad_checks);
    int lat, e, w, pos, cand, cursor, fail, cnt;
    int m_list[$];
    bit placed[N];
    bit cerr;
    logic exp_valid, exp_all;
    logic [N*W-1:0] exp_seq;
    bad_checks = 0;
    m_list = {};
    for (int i = 0; i < N; i++) if (node_valid_mask[i]) m_list.push_back(i);
    w = m_list.size();
    placed = '{default: 1'b0};
    cursor = 0; fail = 0; cnt = 0; cerr = 1'b0; exp_seq = '0; cand = 0;

    do_op(0, lat);
    check_eq({name, "_rst_lat"}, lat, 1);
    check_eq({name, "_rst_cnt"}, seq_count, 0);
    check_eq({name, "_rst_seq"}, node_seq, 0);
    check_eq({name, "_rst_cerr"}, cycle_error, 0);
    do_op(1, lat);
    check_eq({name, "_width_lat"}, lat, N + 1);
    do_op(2, lat);
    check_eq({name, "_elem_lat"}, lat, N + 1);

    for (int it = 0; it < 100; it++) begin
      exp_all = (w == 0) || (cnt == w) || cerr;
      e = 0;
      if (!exp_all) begin
        for (int k = 0; k < w; k++) begin
          pos = (cursor + k) % w;
          if (!placed[m_list[pos]]) begin
            cand   = m_list[pos];
            e      = k + 1;
            cursor = (pos + 1) % w;
            break;
          end
        end
      end
      do_op(3, lat);
      check_eq({name, "_all_set"}, cap_all, exp_all);
      if (exp_all || cap_all) begin
        check_eq({name, "_all_lat"}, lat, 1);
        break;
      end
      check_eq({name, "_choose_lat"}, lat, e + 1);

      exp_valid = 1'b1;
      for (int j = 0; j < N; j++)
        if (dep_mask[cand*N + j] && (!node_valid_mask[j] || !placed[j])) exp_valid = 1'b0;
      do_op(4, lat);
      check_eq({name, "_check_lat"}, lat, 1);
      check_eq({name, "_node_valid"}, cap_valid, exp_valid);
      if (!cap_valid) bad_checks++;
      if (exp_valid) fail = 0;
      else begin
        fail++;
        if (fail == w - cnt) cerr = 1'b1;
      end
      check_eq({name, "_cerr_step"}, cycle_error, cerr);

      if (exp_valid) begin
        do_op(5, lat);
        check_eq({name, "_set_lat"}, lat, 1);
        exp_seq[cnt*W +: W] = cand[W-1:0];
        placed[cand] = 1'b1;
        cnt++;
        fail = 0;
        check_eq({name, "_cnt_step"}, seq_count, cnt);
      end
    end
    check_eq({name, "_final_seq"}, node_seq, exp_seq);
    check_eq({name, "_final_cnt"}, seq_count, cnt);
    check_eq({name, "_final_cerr"}, cycle_error, cerr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, lat;
    logic seen;
    logic [N*W-1:0] inorder;

    program_reset = 1'b1;
    gov = '0;
    node_valid_mask = '0;
    dep_mask = '0;
    step();
    step();
    program_reset = 1'b0;
    check_eq("reset_outputs", out_vec(), 64'd0);

    // Handshake: go_reset_data held for 5 cycles.
    gov[0] = 1'b1;
    #1;
    check_eq("hs_c1", data_reset_done, 1'b0);
    for (int c = 2; c <= 5; c++) begin
      step();
      check_eq($sformatf("hs_c%0d", c), data_reset_done, 1'b1);
    end
    step();
    gov[0] = 1'b0;
    #1;
    check_eq("hs_c6", data_reset_done, 1'b0);
    step();
    check_eq("hs_c7", data_reset_done, 1'b0);

    // Chain: node 1 needs 0, 2 needs 1, 3 needs 2.
    node_valid_mask = 8'h0F;
    dep_mask = '0;
    dep_mask[1*N + 0] = 1'b1;
    dep_mask[2*N + 1] = 1'b1;
    dep_mask[3*N + 2] = 1'b1;
    run_sort("chain", bad);
    check_eq("chain_slots", node_seq[11:0], {3'd3, 3'd2, 3'd1, 3'd0});
    check_eq("chain_cnt", seq_count, 4);
    check_eq("chain_cerr", cycle_error, 1'b0);

    // Reset in the middle of a width scan.
    gov[1] = 1'b1;
    step();
    step();
    step();
    program_reset = 1'b1;
    step();
    program_reset = 1'b0;
    check_eq("midreset_outputs", out_vec(), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (width_calculated) seen = 1'b1;
    end
    check_eq("midreset_no_width", seen, 1'b0);
    gov[1] = 1'b0;
    step();

    // Independent nodes.
    node_valid_mask = 8'hFF;
    dep_mask = '0;
    run_sort("indep", bad);
    for (int k = 0; k < N; k++) inorder[k*W +: W] = k[W-1:0];
    check_eq("indep_seq", node_seq, inorder);
    check_eq("indep_cnt", seq_count, 8);
    check_eq("indep_fails", bad, 0);

    // Two-node cycle plus one free node.
    node_valid_mask = 8'h07;
    dep_mask = '0;
    dep_mask[0*N + 1] = 1'b1;
    dep_mask[1*N + 0] = 1'b1;
    run_sort("cycle", bad);
    check_eq("cycle_slot0", node_seq[2:0], 3'd2);
    check_eq("cycle_cnt", seq_count, 1);
    check_eq("cycle_err", cycle_error, 1'b1);
    check_eq("cycle_fails", bad, 4);

    // Empty mask.
    node_valid_mask = 8'h00;
    dep_mask = '0;
    run_sort("empty", bad);
    check_eq("empty_cnt", seq_count, 0);

    // Randomized graphs: mostly backward edges, some forward edges and references to invalid nodes.
    for (int t = 0; t < 25; t++) begin
      node_valid_mask = N'($urandom_range(0, 255));
      dep_mask = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          int r;
          r = $urandom_range(0, 99);
          if (j != i && ((j < i && r < 30) || (j > i && r < 4) || r == 99)) dep_mask[i*N + j] = 1'b1;
        end
      end
      run_sort($sformatf("rand%0d", t), bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
